// File: rtl/vga3_scanline_if.sv
// Span-fragment and Z-buffer pixel bundle for the vga3 scanline walker.
// The walker uses the slave view: it accepts fragments and produces pixels.
// The master view belongs to the environment, which supplies fragments and
// sinks pixels.
interface vga3_scanline_if #(
  parameter int NATTR  = 3,
  parameter int OUT_W  = 16,
  parameter int XOUT_W = 10
);
  // fragment handshake from the object processor
  logic                      scanline_ready;
  logic                      scanline_valid;
  logic signed [15:0]        scanline_x1;
  logic signed [15:0]        scanline_x2;
  logic [NATTR*32-1:0]       scanline_attr;
  logic [NATTR*32-1:0]       scanline_dattr;

  // pixel handshake toward the Z buffer
  logic                      zbuf_ready;
  logic                      zbuf_valid;
  logic [XOUT_W-1:0]         zbuf_x;
  logic [NATTR*OUT_W-1:0]    zbuf_attr;
  logic                      zbuf_last;

  modport slave (
    output scanline_ready,
    input  scanline_valid,
    input  scanline_x1,
    input  scanline_x2,
    input  scanline_attr,
    input  scanline_dattr,
    input  zbuf_ready,
    output zbuf_valid,
    output zbuf_x,
    output zbuf_attr,
    output zbuf_last
  );

  modport master (
    input  scanline_ready,
    output scanline_valid,
    output scanline_x1,
    output scanline_x2,
    output scanline_attr,
    output scanline_dattr,
    output zbuf_ready,
    input  zbuf_valid,
    input  zbuf_x,
    input  zbuf_attr,
    input  zbuf_last
  );
endinterface

// File: rtl/vga3_scanline.sv
// vga3_scanline: horizontal span walker. Takes one span fragment (x1 inclusive,
// x2 exclusive, NATTR fixed-point start values and per-pixel slopes), clips it
// to [0, SCREEN_W), pre-steps the attributes over any clipped-off left part,
// and then emits one pixel per accepted Z-buffer handshake. Empty or fully
// offscreen spans are dropped without emitting anything.
//
// All outputs come straight from flops: scanline_ready and zbuf_valid are
// registered copies of the next-state decode, zbuf_x / zbuf_last / zbuf_attr
// are the walking registers themselves, so they only change on a handshake.
module vga3_scanline #(
  parameter int NATTR    = 3,
  parameter int FRAC     = 16,
  parameter int OUT_W    = 16,
  parameter int XOUT_W   = 10,
  parameter int SCREEN_W = 640
) (
  input  logic           clock,
  input  logic           reset,
  vga3_scanline_if.slave bus
);

  localparam int                 ACC_W    = 32;
  localparam logic signed [15:0] SCREEN_X = 16'(SCREEN_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESTEP = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // control flops
  logic ready_q;
  logic vld_q;
  logic last_q;

  // captured fragment
  logic signed [15:0]      x1_q;
  logic signed [15:0]      x2_q;
  logic signed [ACC_W-1:0] dattr_q [NATTR];

  // walking datapath
  logic signed [15:0]      x_q;
  logic signed [15:0]      xe_q;
  logic signed [ACC_W-1:0] acc_q [NATTR];

  // clip results, valid while in PRESTEP
  logic signed [15:0] xs_c;
  logic signed [15:0] xe_c;
  logic [15:0]        pre_n;
  logic               empty_c;

  logic accept;
  logic advance;

  // Pre-step amount: |x1| pixels as an unsigned 16-bit count times a signed
  // 32-bit slope, keeping only the low 32 bits. Two's complement makes the
  // low half identical for signed and unsigned operands, so a plain 32x32
  // multiply on the zero-extended count is exact modulo 2^32.
  function automatic logic signed [ACC_W-1:0] prestep_mul(input logic [15:0] n,
                                                         input logic [ACC_W-1:0] d);
    logic [ACC_W-1:0] nz;
    logic [ACC_W-1:0] p;
    nz = {16'd0, n};
    p  = nz * d;
    return $signed(p);
  endfunction

  // Clip the captured span against the screen and size the left pre-step.
  always_comb begin
    xs_c    = (x1_q < 16'sd0) ? 16'sd0 : x1_q;
    xe_c    = (x2_q > SCREEN_X) ? SCREEN_X : x2_q;
    empty_c = (xe_c <= xs_c);
    pre_n   = x1_q[15] ? $unsigned(-x1_q) : 16'd0;
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.scanline_valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = PRESTEP;
        end
      end
      PRESTEP: begin
        state_nxt = empty_c ? IDLE : RUN;
      end
      RUN: begin
        if (vld_q && bus.zbuf_ready) begin
          if (last_q) begin
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with registered ready/valid derived from the next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ready_q <= (state_nxt == IDLE);
      vld_q   <= (state_nxt == RUN);
    end
  end

  // Fragment capture; these are only read after an accept, so no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      x1_q <= bus.scanline_x1;
      x2_q <= bus.scanline_x2;
      for (int i = 0; i < NATTR; i++) begin
        dattr_q[i] <= $signed(bus.scanline_dattr[32*i +: 32]);
      end
    end
  end

  // Walking registers: load on accept, pre-step and clip in PRESTEP, step on
  // each pixel handshake. Cleared on reset so the pixel outputs read zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q    <= 16'sd0;
      xe_q   <= 16'sd0;
      last_q <= 1'b0;
      for (int i = 0; i < NATTR; i++) begin
        acc_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NATTR; i++) begin
        acc_q[i] <= $signed(bus.scanline_attr[32*i +: 32]);
      end
    end else if (state_q == PRESTEP) begin
      x_q    <= xs_c;
      xe_q   <= xe_c;
      last_q <= ((xs_c + 16'sd1) == xe_c);
      for (int i = 0; i < NATTR; i++) begin
        acc_q[i] <= acc_q[i] + prestep_mul(pre_n, dattr_q[i]);
      end
    end else if (advance) begin
      x_q    <= x_q + 16'sd1;
      last_q <= ((x_q + 16'sd2) == xe_q);
      for (int i = 0; i < NATTR; i++) begin
        acc_q[i] <= acc_q[i] + dattr_q[i];
      end
    end
  end

  assign bus.scanline_ready = ready_q;
  assign bus.zbuf_valid     = vld_q;
  assign bus.zbuf_x         = x_q[XOUT_W-1:0];
  assign bus.zbuf_last      = last_q;

  // Integer part of each accumulator: a plain slice, i.e. floor toward -inf.
  for (genvar g = 0; g < NATTR; g++) begin : g_attr_out
    assign bus.zbuf_attr[OUT_W*g +: OUT_W] = acc_q[g][FRAC+OUT_W-1:FRAC];
  end

endmodule

// File: tb/tb_vga3_scanline.sv
// Testbench for vga3_scanline: directed and randomized spans checked against a
// closed-form model (attr at pixel x = start + slope*(x - x1), modulo 2^32).
module tb_vga3_scanline;

  localparam int NATTR    = 3;
  localparam int FRAC     = 16;
  localparam int OUT_W    = 16;
  localparam int XOUT_W   = 10;
  localparam int SCREEN_W = 640;

  typedef struct {
    logic [XOUT_W-1:0]      x;
    logic [NATTR*OUT_W-1:0] attr;
    logic                   last;
  } pix_t;

  logic clock;
  logic reset;

  vga3_scanline_if #(.NATTR(NATTR), .OUT_W(OUT_W), .XOUT_W(XOUT_W)) sif ();

  vga3_scanline #(
    .NATTR(NATTR), .FRAC(FRAC), .OUT_W(OUT_W), .XOUT_W(XOUT_W), .SCREEN_W(SCREEN_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  pix_t got_q[$];
  pix_t exp_q[$];
  int   first_vld;
  int   rdy_back;
  int   stall_bad;
  int   vld_cycles;
  bit   timed_out;

  // Expected pixel list from the span rules alone.
  function automatic void model_span(input int x1, input int x2,
                                     input logic [NATTR*32-1:0] a,
                                     input logic [NATTR*32-1:0] d);
    int          xs, xe;
    pix_t        p;
    logic [31:0] acc;
    longint      ai, di;
    exp_q.delete();
    xs = (x1 < 0) ? 0 : x1;
    xe = (x2 > SCREEN_W) ? SCREEN_W : x2;
    for (int x = xs; x < xe; x++) begin
      p.x    = XOUT_W'(x);
      p.last = (x == xe - 1);
      p.attr = '0;
      for (int i = 0; i < NATTR; i++) begin
        ai  = longint'($signed(a[32*i +: 32]));
        di  = longint'($signed(d[32*i +: 32]));
        acc = 32'(ai + di * longint'(x - x1));
        p.attr[OUT_W*i +: OUT_W] = acc[FRAC+OUT_W-1:FRAC];
      end
      exp_q.push_back(p);
    end
  endfunction

  // Drive one fragment and collect every pixel handshake until ready returns.
  // mode 0: zbuf_ready high; 1: 1,0,0 repeating over valid cycles; 2: random.
  task automatic run_span(input int x1, input int x2,
                          input logic [NATTR*32-1:0] a,
                          input logic [NATTR*32-1:0] d, input int mode);
    int   k, guard, pc;
    bit   prev_stall, rdy;
    pix_t prev, cur;
    got_q.delete();
    first_vld = -1; rdy_back = -1; stall_bad = 0; vld_cycles = 0; timed_out = 0;
    guard = 0;
    while (!sif.scanline_ready && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    if (!sif.scanline_ready) timed_out = 1;
    sif.scanline_valid = 1'b1;
    sif.scanline_x1    = 16'(x1);
    sif.scanline_x2    = 16'(x2);
    sif.scanline_attr  = a;
    sif.scanline_dattr = d;
    @(posedge clock); #1;
    sif.scanline_valid = 1'b0;
    k = 1; pc = 0; prev_stall = 0;
    prev = '{x: '0, attr: '0, last: 1'b0};
    while (k < 2000) begin
      cur.x    = sif.zbuf_x;
      cur.attr = sif.zbuf_attr;
      cur.last = sif.zbuf_last;
      if (sif.scanline_ready) begin
        rdy_back = k;
        break;
      end
      if (prev_stall && (!sif.zbuf_valid || cur.x !== prev.x ||
                         cur.attr !== prev.attr || cur.last !== prev.last))
        stall_bad++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.zbuf_ready = rdy;
      if (sif.zbuf_valid) begin
        vld_cycles++;
        pc++;
        if (first_vld < 0) first_vld = k;
        if (rdy) got_q.push_back(cur);
      end
      prev_stall = sif.zbuf_valid && !rdy;
      prev       = cur;
      @(posedge clock); #1;
      k++;
    end
    sif.zbuf_ready = 1'b1;
    if (rdy_back < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sif.scanline_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", sif.scanline_ready);
    end
    checks++;
    if (sif.zbuf_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", sif.zbuf_valid);
    end
    checks++;
    if (sif.zbuf_x !== '0) begin
      failures++; $display("FAIL reset_x got=%0d exp=0", sif.zbuf_x);
    end
    checks++;
    if (sif.zbuf_attr !== '0) begin
      failures++; $display("FAIL reset_attr got=%h exp=0", sif.zbuf_attr);
    end
    checks++;
    if (sif.zbuf_last !== 1'b0) begin
      failures++; $display("FAIL reset_last got=%b exp=0", sif.zbuf_last);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (sif.scanline_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", sif.scanline_ready);
    end
  endtask

  task automatic test_basic();
    logic [NATTR*32-1:0] a, d;
    a = {$urandom, $urandom, 32'h0005_0000};
    d = {$urandom, $urandom, 32'h0001_0000};
    model_span(10, 13, a, d);
    run_span(10, 13, a, d, 0);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++;
    if (got_q.size() !== 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].x !== XOUT_W'(10 + i) || got_q[i].attr[15:0] !== 16'(5 + i) ||
          got_q[i].last !== (i == 2)) begin
        failures++;
        $display("FAIL basic_pix%0d got x=%0d a0=%0d last=%b exp x=%0d a0=%0d last=%b",
                 i, got_q[i].x, got_q[i].attr[15:0], got_q[i].last, 10 + i, 5 + i, i == 2);
      end
      checks++;
      if (got_q[i].attr !== exp_q[i].attr) begin
        failures++; $display("FAIL basic_attr%0d got=%h exp=%h", i, got_q[i].attr, exp_q[i].attr);
      end
    end
    checks++;
    if (first_vld !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", first_vld); end
    checks++;
    if (rdy_back !== 5) begin failures++; $display("FAIL basic_ready_back got=%0d exp=5", rdy_back); end
    checks++;
    if (vld_cycles !== 3) begin failures++; $display("FAIL basic_vld_cycles got=%0d exp=3", vld_cycles); end
  endtask

  task automatic test_backpressure();
    logic [NATTR*32-1:0] a, d;
    a = {$urandom, $urandom, 32'h0005_0000};
    d = {$urandom, $urandom, 32'h0001_0000};
    model_span(10, 13, a, d);
    run_span(10, 13, a, d, 1);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].x !== exp_q[i].x || got_q[i].attr !== exp_q[i].attr ||
          got_q[i].last !== exp_q[i].last) begin
        failures++;
        $display("FAIL bp_pix%0d got x=%0d attr=%h last=%b exp x=%0d attr=%h last=%b", i,
                 got_q[i].x, got_q[i].attr, got_q[i].last, exp_q[i].x, exp_q[i].attr, exp_q[i].last);
      end
    end
    checks++;
    if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
  endtask

  task automatic test_left_clip();
    logic [NATTR*32-1:0] a, d;
    a = {$urandom, 32'h0000_0000, $urandom};
    d = {$urandom, 32'h0000_8000, $urandom};
    model_span(-4, 2, a, d);
    run_span(-4, 2, a, d, 0);
    checks++;
    if (got_q.size() !== 2 || timed_out) begin
      failures++; $display("FAIL lclip_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].x !== 0 || got_q[0].attr[31:16] !== 16'd2 || got_q[0].last !== 1'b0) begin
        failures++; $display("FAIL lclip_pix0 got x=%0d a1=%0d last=%b exp x=0 a1=2 last=0",
                             got_q[0].x, got_q[0].attr[31:16], got_q[0].last);
      end
      checks++;
      if (got_q[1].x !== 1 || got_q[1].attr[31:16] !== 16'd2 || got_q[1].last !== 1'b1) begin
        failures++; $display("FAIL lclip_pix1 got x=%0d a1=%0d last=%b exp x=1 a1=2 last=1",
                             got_q[1].x, got_q[1].attr[31:16], got_q[1].last);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i].attr !== exp_q[i].attr) begin
          failures++; $display("FAIL lclip_attr%0d got=%h exp=%h", i, got_q[i].attr, exp_q[i].attr);
        end
      end
    end
  endtask

  task automatic test_right_clip();
    logic [NATTR*32-1:0] a, d;
    a = {$urandom, $urandom, $urandom};
    d = {$urandom, $urandom, $urandom};
    model_span(637, 700, a, d);
    run_span(637, 700, a, d, 0);
    checks++;
    if (got_q.size() !== 3 || timed_out) begin
      failures++; $display("FAIL rclip_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i].x !== XOUT_W'(637 + i) || got_q[i].last !== (i == 2) ||
            got_q[i].attr !== exp_q[i].attr) begin
          failures++;
          $display("FAIL rclip_pix%0d got x=%0d attr=%h last=%b exp x=%0d attr=%h last=%b", i,
                   got_q[i].x, got_q[i].attr, got_q[i].last, 637 + i, exp_q[i].attr, i == 2);
        end
      end
    end
  endtask

  task automatic test_empty();
    int ex1[4] = '{5, 9, 650, -20};
    int ex2[4] = '{5, 3, 700, 0};
    for (int s = 0; s < 4; s++) begin
      run_span(ex1[s], ex2[s], {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 0);
      checks++;
      if (vld_cycles !== 0) begin
        failures++; $display("FAIL empty%0d_valid got=%0d exp=0", s, vld_cycles);
      end
      checks++;
      if (rdy_back !== 2) begin
        failures++; $display("FAIL empty%0d_ready_back got=%0d exp=2", s, rdy_back);
      end
    end
  endtask

  task automatic test_random();
    int x1, x2, mode;
    logic [NATTR*32-1:0] a, d;
    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 5) begin
        x1 = -int'($urandom_range(100, 32768));
        x2 = int'($urandom_range(0, 20));
      end else begin
        x1 = int'($urandom_range(0, 720)) - 40;
        x2 = x1 + int'($urandom_range(0, 45)) - 5;
      end
      a    = {$urandom, $urandom, $urandom};
      d    = {$urandom, $urandom, $urandom};
      mode = t % 3;
      model_span(x1, x2, a, d);
      run_span(x1, x2, a, d, mode);
      checks++;
      if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count span=%0d..%0d got=%0d exp=%0d timeout=%b",
                 t, x1, x2, got_q.size(), exp_q.size(), timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i].x !== exp_q[i].x || got_q[i].attr !== exp_q[i].attr ||
            got_q[i].last !== exp_q[i].last) begin
          failures++;
          $display("FAIL rand%0d_pix%0d got x=%0d attr=%h last=%b exp x=%0d attr=%h last=%b", t, i,
                   got_q[i].x, got_q[i].attr, got_q[i].last, exp_q[i].x, exp_q[i].attr, exp_q[i].last);
        end
      end
      checks++;
      if (stall_bad !== 0) begin failures++; $display("FAIL rand%0d_stall got=%0d exp=0", t, stall_bad); end
      if (mode == 0) begin
        checks++;
        if (rdy_back !== exp_q.size() + 2) begin
          failures++; $display("FAIL rand%0d_ready_back got=%0d exp=%0d", t, rdy_back, exp_q.size() + 2);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int n, guard;
    n = 0; guard = 0;
    sif.zbuf_ready = 1'b1;
    while (!sif.scanline_ready && guard < 50) begin @(posedge clock); #1; guard++; end
    sif.scanline_valid = 1'b1;
    sif.scanline_x1    = 16'sd0;
    sif.scanline_x2    = 16'sd100;
    sif.scanline_attr  = {$urandom, $urandom, $urandom};
    sif.scanline_dattr = {$urandom, $urandom, $urandom};
    @(posedge clock); #1;
    sif.scanline_valid = 1'b0;
    guard = 0;
    while (n < 21 && guard < 200) begin
      if (sif.zbuf_valid) n++;
      @(posedge clock); #1;
      guard++;
    end
    checks++;
    if (n !== 21) begin failures++; $display("FAIL midrun_pixels got=%0d exp=21", n); end
    reset = 1'b0;
    sif.zbuf_ready = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (sif.zbuf_valid !== 1'b0 || sif.scanline_ready !== 1'b0) begin
      failures++; $display("FAIL midrun_reset got valid=%b ready=%b exp valid=0 ready=0",
                           sif.zbuf_valid, sif.scanline_ready);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (sif.zbuf_valid !== 1'b0) begin failures++; $display("FAIL midrun_after got=%b exp=0", sif.zbuf_valid); end
    run_span(0, 2, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 0);
    checks++;
    if (got_q.size() !== 2 || timed_out) begin
      failures++; $display("FAIL midrun_new_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].x !== 0 || got_q[1].x !== 1 || got_q[0].last !== 1'b0 || got_q[1].last !== 1'b1) begin
        failures++; $display("FAIL midrun_new_pix got x=%0d,%0d last=%b,%b exp x=0,1 last=0,1",
                             got_q[0].x, got_q[1].x, got_q[0].last, got_q[1].last);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    sif.scanline_valid = 1'b0;
    sif.scanline_x1    = '0;
    sif.scanline_x2    = '0;
    sif.scanline_attr  = '0;
    sif.scanline_dattr = '0;
    sif.zbuf_ready     = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_left_clip();
    test_right_clip();
    test_empty();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
